// File: rtl/axil_regfile.sv
// axil_regfile: parametrised AXI4-Lite slave register file.
//   P_NUM_RW_REG host-writable control registers with byte strobes, followed in
//   the address map by P_NUM_RO_REG read-only status inputs. Word index is
//   addr[P_ADDR_WIDTH-1:2]; anything past the last RO register answers DECERR.
//   Writes to RO registers answer SLVERR. Per-register write/read pulses let
//   the PL side react to host accesses (e.g. clear-on-read status).
//   P_DATA_WIDTH must be 32 or 64; P_ADDR_WIDTH must be at least 3 and wide
//   enough to index every register.
module axil_regfile #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_NUM_RW_REG = 4,
    parameter int P_NUM_RO_REG = 4,
    parameter int P_ADDR_WIDTH = $clog2(P_NUM_RW_REG + P_NUM_RO_REG) + 2,
    parameter logic [P_NUM_RW_REG*P_DATA_WIDTH-1:0] P_RW_RESET = '0
) (
    input  logic                                 s_axi_aclk,
    input  logic                                 s_axi_areset,
    // write address channel
    input  logic [P_ADDR_WIDTH-1:0]              s_axi_awaddr,
    input  logic [2:0]                           s_axi_awprot,
    input  logic                                 s_axi_awvalid,
    output logic                                 s_axi_awready,
    // write data channel
    input  logic [P_DATA_WIDTH-1:0]              s_axi_wdata,
    input  logic [P_DATA_WIDTH/8-1:0]            s_axi_wstrb,
    input  logic                                 s_axi_wvalid,
    output logic                                 s_axi_wready,
    // write response channel
    output logic [1:0]                           s_axi_bresp,
    output logic                                 s_axi_bvalid,
    input  logic                                 s_axi_bready,
    // read address channel
    input  logic [P_ADDR_WIDTH-1:0]              s_axi_araddr,
    input  logic [2:0]                           s_axi_arprot,
    input  logic                                 s_axi_arvalid,
    output logic                                 s_axi_arready,
    // read data channel
    output logic [P_DATA_WIDTH-1:0]              s_axi_rdata,
    output logic [1:0]                           s_axi_rresp,
    output logic                                 s_axi_rvalid,
    input  logic                                 s_axi_rready,
    // register-side interface
    output logic [P_NUM_RW_REG*P_DATA_WIDTH-1:0] rw_data,
    output logic [P_NUM_RW_REG-1:0]              rw_wr_pulse,
    input  logic [P_NUM_RO_REG*P_DATA_WIDTH-1:0] ro_data,
    output logic [P_NUM_RO_REG-1:0]              ro_rd_pulse
);

    localparam int STRB_W = P_DATA_WIDTH / 8;
    localparam int IDX_W  = P_ADDR_WIDTH - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Write-side state: independently held AW and W beats, then the B response.
    logic                    aw_held;
    logic                    w_held;
    logic [IDX_W-1:0]        aw_idx_q;
    logic [P_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]       w_strb_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic [P_NUM_RW_REG-1:0] rw_wr_pulse_q;

    // Read-side state: single registered response slot.
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic [P_DATA_WIDTH-1:0] rdata_q;
    logic [P_NUM_RO_REG-1:0] ro_rd_pulse_q;

    // Control register storage.
    logic [P_DATA_WIDTH-1:0] rw_regs [P_NUM_RW_REG];

    // Handshakes and commit strobe.
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             ar_hs;
    logic             r_hs;
    logic             commit;
    logic [IDX_W-1:0] ar_idx;

    // Decode results.
    logic [P_NUM_RW_REG-1:0] wr_rw_hit;
    logic                    wr_ro_hit;
    logic [P_NUM_RW_REG-1:0] rd_rw_hit;
    logic [P_NUM_RO_REG-1:0] rd_ro_hit;
    logic [P_DATA_WIDTH-1:0] rd_data_mux;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_sink;
    assign unused_sink = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Ready terms are gated by reset so nothing is accepted while it is asserted.
    assign s_axi_awready = ~aw_held & ~bvalid_q & ~s_axi_areset;
    assign s_axi_wready  = ~w_held  & ~bvalid_q & ~s_axi_areset;
    assign s_axi_arready = ~rvalid_q & ~s_axi_areset;

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid  & s_axi_wready;
    assign b_hs   = bvalid_q & s_axi_bready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign r_hs   = rvalid_q & s_axi_rready;
    // Both halves present: the write lands on the following edge.
    assign commit = aw_held & w_held;
    assign ar_idx = s_axi_araddr[P_ADDR_WIDTH-1:2];

    // Decode the held write index into a one-hot RW hit or an RO hit.
    always_comb begin
        wr_rw_hit = '0;
        wr_ro_hit = 1'b0;
        for (int i = 0; i < P_NUM_RW_REG; i++) begin
            if (aw_idx_q == IDX_W'(i)) wr_rw_hit[i] = 1'b1;
        end
        for (int j = 0; j < P_NUM_RO_REG; j++) begin
            if (aw_idx_q == IDX_W'(P_NUM_RW_REG + j)) wr_ro_hit = 1'b1;
        end
    end

    // Decode the live read index and select the word to return (0 if unmapped).
    always_comb begin
        rd_rw_hit   = '0;
        rd_ro_hit   = '0;
        rd_data_mux = '0;
        for (int i = 0; i < P_NUM_RW_REG; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_rw_hit[i] = 1'b1;
                rd_data_mux  = rw_regs[i];
            end
        end
        for (int j = 0; j < P_NUM_RO_REG; j++) begin
            if (ar_idx == IDX_W'(P_NUM_RW_REG + j)) begin
                rd_ro_hit[j] = 1'b1;
                rd_data_mux  = ro_data[j*P_DATA_WIDTH +: P_DATA_WIDTH];
            end
        end
    end

    // Capture the write address and data payloads as each beat is accepted.
    always_ff @(posedge s_axi_aclk) begin
        if (aw_hs) aw_idx_q <= s_axi_awaddr[P_ADDR_WIDTH-1:2];
        if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
        end
    end

    // Write control: held flags, commit into a B response, and the write pulse.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            rw_wr_pulse_q <= '0;
        end else begin
            rw_wr_pulse_q <= '0;
            if (aw_hs) aw_held <= 1'b1;
            if (w_hs)  w_held  <= 1'b1;
            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                bvalid_q      <= 1'b1;
                rw_wr_pulse_q <= wr_rw_hit;
                if (|wr_rw_hit)     bresp_q <= RESP_OKAY;
                else if (wr_ro_hit) bresp_q <= RESP_SLVERR;
                else                bresp_q <= RESP_DECERR;
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
                bresp_q  <= RESP_OKAY;
            end
        end
    end

    // Register storage: byte-lane update of the addressed RW register on commit.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            for (int i = 0; i < P_NUM_RW_REG; i++) begin
                rw_regs[i] <= P_RW_RESET[i*P_DATA_WIDTH +: P_DATA_WIDTH];
            end
        end else if (commit) begin
            for (int i = 0; i < P_NUM_RW_REG; i++) begin
                if (wr_rw_hit[i]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) rw_regs[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read response: registered on the AR handshake, cleared on the R handshake.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rvalid_q      <= 1'b0;
            rresp_q       <= RESP_OKAY;
            rdata_q       <= '0;
            ro_rd_pulse_q <= '0;
        end else begin
            ro_rd_pulse_q <= '0;
            if (ar_hs) begin
                rvalid_q      <= 1'b1;
                rdata_q       <= rd_data_mux;
                rresp_q       <= ((|rd_rw_hit) || (|rd_ro_hit)) ? RESP_OKAY : RESP_DECERR;
                ro_rd_pulse_q <= rd_ro_hit;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
                rresp_q  <= RESP_OKAY;
                rdata_q  <= '0;
            end
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;
    assign rw_wr_pulse  = rw_wr_pulse_q;
    assign ro_rd_pulse  = ro_rd_pulse_q;

    for (genvar g = 0; g < P_NUM_RW_REG; g++) begin : g_rw_out
        assign rw_data[g*P_DATA_WIDTH +: P_DATA_WIDTH] = rw_regs[g];
    end

endmodule

// File: tb/tb_axil_regfile.sv
// tb_axil_regfile: scoreboard bench for axil_regfile (4 RW, 4 RO, 6-bit address).
module tb_axil_regfile;

    localparam int DW = 32;
    localparam int RW = 4;
    localparam int RO = 4;
    localparam int AW = 6;
    localparam logic [RW*DW-1:0] RST_VALS = {32'h0, 32'h0, 32'hA5A5_0000, 32'h0};

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic             clk = 1'b0;
    logic             areset = 1'b1;
    logic [AW-1:0]    awaddr = '0;
    logic [2:0]       awprot = '0;
    logic             awvalid = 1'b0;
    logic             awready;
    logic [DW-1:0]    wdata = '0;
    logic [DW/8-1:0]  wstrb = '0;
    logic             wvalid = 1'b0;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready = 1'b0;
    logic [AW-1:0]    araddr = '0;
    logic [2:0]       arprot = '0;
    logic             arvalid = 1'b0;
    logic             arready;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready = 1'b0;
    logic [RW*DW-1:0] rw_data;
    logic [RW-1:0]    rw_wr_pulse;
    logic [RO*DW-1:0] ro_data = {32'h4444_0004, 32'h3333_0003, 32'h0000_CAFE, 32'h1111_0001};
    logic [RO-1:0]    ro_rd_pulse;

    axil_regfile #(
        .P_DATA_WIDTH(DW), .P_NUM_RW_REG(RW), .P_NUM_RO_REG(RO),
        .P_ADDR_WIDTH(AW), .P_RW_RESET(RST_VALS)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(areset),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .rw_data(rw_data), .rw_wr_pulse(rw_wr_pulse), .ro_data(ro_data), .ro_rd_pulse(ro_rd_pulse)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic [RO-1:0] pulse; } rd_exp_t;
    typedef struct { logic [1:0] resp; logic [RW-1:0] pulse; } wr_exp_t;

    rd_exp_t       rd_q[$];
    wr_exp_t       wr_q[$];
    logic [DW-1:0] model_rw [RW];
    logic [RW*DW-1:0] rst_copy;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        rst_copy = RST_VALS;
        for (int i = 0; i < RW; i++) model_rw[i] = rst_copy[i*DW +: DW];
    endtask

    function automatic logic [RW*DW-1:0] model_flat();
        logic [RW*DW-1:0] f;
        for (int i = 0; i < RW; i++) f[i*DW +: DW] = model_rw[i];
        return f;
    endfunction

    // Expected write response; applies the write to the model when it targets a RW reg.
    function automatic wr_exp_t model_write(input int idx, input logic [DW-1:0] d, input logic [3:0] s);
        wr_exp_t e;
        e.pulse = '0;
        if (idx < RW) begin
            for (int b = 0; b < 4; b++) if (s[b]) model_rw[idx][b*8 +: 8] = d[b*8 +: 8];
            e.resp  = OKAY;
            e.pulse = RW'(1 << idx);
        end else if (idx < RW + RO) begin
            e.resp = SLVERR;
        end else begin
            e.resp = DECERR;
        end
        return e;
    endfunction

    function automatic rd_exp_t model_read(input int idx);
        rd_exp_t e;
        e.data = '0; e.resp = DECERR; e.pulse = '0;
        if (idx < RW) begin
            e.data = model_rw[idx]; e.resp = OKAY;
        end else if (idx < RW + RO) begin
            e.data  = ro_data[(idx-RW)*DW +: DW];
            e.resp  = OKAY;
            e.pulse = RO'(1 << (idx - RW));
        end
        return e;
    endfunction

    // Drives AW and W with independent start delays, then waits for bvalid (bready kept low).
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output logic [RW-1:0] pulse,
                            output int lat, output int wready_hi, output bit ok);
        bit aw_done, w_done, aw_now, w_now;
        aw_done = 0; w_done = 0; ok = 0; lat = 0; wready_hi = 0; resp = '0; pulse = '0;
        awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
        for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
            awvalid = (!aw_done && c >= aw_dly);
            wvalid  = (!w_done && c >= w_dly);
            if (w_done && wready) wready_hi++;
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            tick();
            if (aw_now) aw_done = 1;
            if (w_now)  w_done = 1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (aw_done && w_done) begin
            for (int k = 0; k < 20; k++) begin
                if (bvalid) begin
                    ok = 1; resp = bresp; pulse = rw_wr_pulse;
                    break;
                end
                if (wready) wready_hi++;
                tick(); lat++;
            end
        end
    endtask

    // Issues one AR and waits for rvalid (rready kept low).
    task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp,
                           output logic [RO-1:0] pulse, output bit ok);
        bit hs;
        hs = 0; ok = 0; data = '0; resp = '0; pulse = '0;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (arready) begin tick(); hs = 1; break; end
            tick();
        end
        arvalid = 1'b0;
        if (hs) begin
            for (int k = 0; k < 20; k++) begin
                if (rvalid) begin
                    ok = 1; data = rdata; resp = rresp; pulse = ro_rd_pulse;
                    break;
                end
                tick();
            end
        end
    endtask

    task automatic b_accept();
        bready = 1'b1; tick(); bready = 1'b0;
    endtask

    task automatic r_accept();
        rready = 1'b1; tick(); rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d; logic [1:0] r; logic [RO-1:0] p; bit ok; rd_exp_t e;
        areset = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ready_valid: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
        end
        n_cmp++;
        if ({bresp, rresp, rdata, rw_wr_pulse, ro_rd_pulse} !== '0) begin
            n_bad++; $display("FAIL reset_resp_data_pulse: got %h required 0", {bresp, rresp, rdata, rw_wr_pulse, ro_rd_pulse});
        end
        n_cmp++;
        if (rw_data !== RST_VALS) begin
            n_bad++; $display("FAIL reset_rw_data: got %h required %h", rw_data, RST_VALS);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        areset = 1'b0;
        tick();
        rd_q.push_back(model_read(1));
        do_read(6'h04, d, r, p, ok);
        e = rd_q.pop_front();
        n_cmp++;
        if (!ok || {d, r, p} !== {e.data, e.resp, e.pulse}) begin
            n_bad++; $display("FAIL reset_read_reg1: got ok=%0d %h/%b/%b required %h/%b/%b", ok, d, r, p, e.data, e.resp, e.pulse);
        end
        r_accept();
        n_cmp++;
        if ({rvalid, rdata} !== '0) begin
            n_bad++; $display("FAIL r_clear_after_rready: got rvalid=%b rdata=%h required 0/0", rvalid, rdata);
        end
    endtask

    task automatic test_write_same_cycle();
        logic [1:0] r; logic [RW-1:0] p; int lat, whi; bit ok; wr_exp_t e;
        wr_q.push_back(model_write(2, 32'h1234_5678, 4'hF));
        do_write(6'h08, 32'h1234_5678, 4'hF, 0, 0, r, p, lat, whi, ok);
        e = wr_q.pop_front();
        n_cmp++;
        if (!ok || {r, p} !== {e.resp, e.pulse}) begin
            n_bad++; $display("FAIL same_cycle_b: got ok=%0d resp=%b pulse=%b required %b/%b", ok, r, p, e.resp, e.pulse);
        end
        n_cmp++;
        if (lat !== 1) begin
            n_bad++; $display("FAIL same_cycle_latency: got %0d required 1", lat);
        end
        n_cmp++;
        if (rw_data !== model_flat()) begin
            n_bad++; $display("FAIL same_cycle_rw_data: got %h required %h", rw_data, model_flat());
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bvalid, bresp, rw_wr_pulse} !== {1'b1, OKAY, 4'b0000}) begin
                n_bad++; $display("FAIL b_hold_%0d: got bvalid=%b bresp=%b pulse=%b required 1/00/0000", i, bvalid, bresp, rw_wr_pulse);
            end
        end
        b_accept();
        n_cmp++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            n_bad++; $display("FAIL b_release: got bvalid/awready/wready=%b required 011", {bvalid, awready, wready});
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r; logic [RW-1:0] p; int lat, whi; bit ok; wr_exp_t e;
        wr_q.push_back(model_write(0, 32'hFFFF_FFFF, 4'h2));
        do_write(6'h00, 32'hFFFF_FFFF, 4'h2, 3, 0, r, p, lat, whi, ok);
        e = wr_q.pop_front();
        n_cmp++;
        if (!ok || {r, p} !== {e.resp, e.pulse}) begin
            n_bad++; $display("FAIL w_first_b: got ok=%0d resp=%b pulse=%b required %b/%b", ok, r, p, e.resp, e.pulse);
        end
        n_cmp++;
        if (rw_data[0 +: DW] !== 32'h0000_FF00) begin
            n_bad++; $display("FAIL w_first_reg0: got %h required 0000ff00", rw_data[0 +: DW]);
        end
        n_cmp++;
        if (whi !== 0 || wready !== 1'b0) begin
            n_bad++; $display("FAIL w_first_wready_low: got %0d high cycles (now %b) required 0", whi, wready);
        end
        b_accept();
    endtask

    task automatic test_ro_access();
        logic [1:0] r; logic [RW-1:0] p; int lat, whi; bit ok; wr_exp_t e;
        logic [DW-1:0] d; logic [RO-1:0] rp; rd_exp_t re;
        wr_q.push_back(model_write(5, 32'h0000_DEAD, 4'hF));
        do_write(6'h14, 32'h0000_DEAD, 4'hF, 0, 1, r, p, lat, whi, ok);
        e = wr_q.pop_front();
        n_cmp++;
        if (!ok || {r, p} !== {e.resp, e.pulse}) begin
            n_bad++; $display("FAIL ro_write_slverr: got ok=%0d resp=%b pulse=%b required %b/%b", ok, r, p, e.resp, e.pulse);
        end
        n_cmp++;
        if (rw_data !== model_flat()) begin
            n_bad++; $display("FAIL ro_write_no_change: got %h required %h", rw_data, model_flat());
        end
        b_accept();
        rd_q.push_back(model_read(5));
        do_read(6'h14, d, r, rp, ok);
        re = rd_q.pop_front();
        n_cmp++;
        if (!ok || {d, r, rp} !== {re.data, re.resp, re.pulse}) begin
            n_bad++; $display("FAIL ro_read: got ok=%0d %h/%b/%b required %h/%b/%b", ok, d, r, rp, re.data, re.resp, re.pulse);
        end
        r_accept();
        n_cmp++;
        if (ro_rd_pulse !== '0) begin
            n_bad++; $display("FAIL ro_pulse_one_cycle: got %b required 0000", ro_rd_pulse);
        end
    endtask

    task automatic test_unmapped();
        logic [1:0] r; logic [RW-1:0] p; int lat, whi; bit ok; wr_exp_t e;
        logic [DW-1:0] d; logic [RO-1:0] rp; rd_exp_t re;
        wr_q.push_back(model_write(9, 32'h0000_DEAD, 4'hF));
        do_write(6'h24, 32'h0000_DEAD, 4'hF, 1, 0, r, p, lat, whi, ok);
        e = wr_q.pop_front();
        n_cmp++;
        if (!ok || {r, p, rw_data} !== {e.resp, e.pulse, model_flat()}) begin
            n_bad++; $display("FAIL unmapped_write: got ok=%0d resp=%b pulse=%b required %b/%b", ok, r, p, e.resp, e.pulse);
        end
        b_accept();
        rd_q.push_back(model_read(9));
        do_read(6'h24, d, r, rp, ok);
        re = rd_q.pop_front();
        n_cmp++;
        if (!ok || {d, r, rp} !== {re.data, re.resp, re.pulse}) begin
            n_bad++; $display("FAIL unmapped_read: got ok=%0d %h/%b/%b required %h/%b/%b", ok, d, r, rp, re.data, re.resp, re.pulse);
        end
        r_accept();
    endtask

    // AR for reg3 lands on the same edge that commits a write to reg3.
    task automatic test_read_during_commit();
        rd_exp_t re; wr_exp_t we;
        rd_q.push_back(model_read(3));
        awaddr = 6'h0C; wdata = 32'hBEEF_0001; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        wr_q.push_back(model_write(3, 32'hBEEF_0001, 4'hF));
        araddr = 6'h0C; arvalid = 1'b1;
        n_cmp++;
        if (arready !== 1'b1) begin
            n_bad++; $display("FAIL commit_race_arready: got %b required 1", arready);
        end
        tick();
        arvalid = 1'b0;
        re = rd_q.pop_front();
        we = wr_q.pop_front();
        n_cmp++;
        if ({rvalid, rdata, rresp} !== {1'b1, re.data, re.resp}) begin
            n_bad++; $display("FAIL commit_race_read_old: got %b/%h/%b required 1/%h/%b", rvalid, rdata, rresp, re.data, re.resp);
        end
        n_cmp++;
        if ({bvalid, bresp, rw_wr_pulse, rw_data} !== {1'b1, we.resp, we.pulse, model_flat()}) begin
            n_bad++; $display("FAIL commit_race_write: got %b/%b/%b %h required 1/%b/%b %h", bvalid, bresp, rw_wr_pulse, rw_data, we.resp, we.pulse, model_flat());
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] r; logic [RW-1:0] p; int lat, whi; bit ok; wr_exp_t e; rd_exp_t re;
        int idx, nxt, got, cyc; logic [DW-1:0] d; logic [3:0] s; bit hs;
        for (int n = 0; n < 10; n++) begin
            idx = $urandom_range(0, 9);
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            wr_q.push_back(model_write(idx, d, s));
            do_write(AW'(idx * 4), d, s, $urandom_range(0, 2), $urandom_range(0, 2), r, p, lat, whi, ok);
            e = wr_q.pop_front();
            n_cmp++;
            if (!ok || {r, p, rw_data} !== {e.resp, e.pulse, model_flat()}) begin
                n_bad++; $display("FAIL rand_write_%0d idx %0d: got ok=%0d %b/%b %h required %b/%b %h", n, idx, ok, r, p, rw_data, e.resp, e.pulse, model_flat());
            end
            b_accept();
        end
        nxt = 0; got = 0; cyc = 0; rready = 1'b1;
        while (got < 10 && cyc < 60) begin
            araddr  = AW'(nxt * 4);
            arvalid = (nxt < 10);
            hs = arvalid && arready;
            if (hs) rd_q.push_back(model_read(nxt));
            tick(); cyc++;
            if (hs) nxt++;
            if (rvalid) begin
                n_cmp++;
                if (rd_q.size() == 0) begin
                    n_bad++; $display("FAIL stream_unexpected_r: got rvalid with empty scoreboard required none");
                end else begin
                    re = rd_q.pop_front();
                    if ({rdata, rresp, ro_rd_pulse} !== {re.data, re.resp, re.pulse}) begin
                        n_bad++; $display("FAIL stream_read_%0d: got %h/%b/%b required %h/%b/%b", got, rdata, rresp, ro_rd_pulse, re.data, re.resp, re.pulse);
                    end
                end
                got++;
            end
        end
        arvalid = 1'b0;
        tick();
        rready = 1'b0;
        n_cmp++;
        if (got !== 10 || cyc !== 19) begin
            n_bad++; $display("FAIL stream_throughput: got %0d reads in %0d cycles required 10 in 19", got, cyc);
        end
    endtask

    task automatic test_hold_and_reset();
        rd_exp_t re;
        re = model_read(2);
        araddr = 6'h08; arvalid = 1'b1; rready = 1'b0;
        awaddr = 6'h00; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({rvalid, rdata, rresp, arready} !== {1'b1, re.data, re.resp, 1'b0}) begin
                n_bad++; $display("FAIL r_hold_%0d: got %b/%h/%b arready=%b required 1/%h/%b 0", i, rvalid, rdata, rresp, arready, re.data, re.resp);
            end
            tick();
        end
        areset = 1'b1;
        tick();
        n_cmp++;
        if ({rvalid, rdata, arready, rw_data} !== {1'b0, 32'h0, 1'b0, RST_VALS}) begin
            n_bad++; $display("FAIL reset_mid_hold: got rvalid=%b rdata=%h arready=%b rw=%h required 0/0/0 %h", rvalid, rdata, arready, rw_data, RST_VALS);
        end
        model_reset();
        arvalid = 1'b0; areset = 1'b0;
        tick();
        // The AW accepted before reset must be gone: a lone W now gets no response.
        wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if ({bvalid, rw_wr_pulse, rw_data} !== {1'b0, 4'b0000, model_flat()}) begin
            n_bad++; $display("FAIL reset_abort_aw: got bvalid=%b pulse=%b rw=%h required 0/0000 %h", bvalid, rw_wr_pulse, rw_data, model_flat());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_ro_access();
        test_unmapped();
        test_read_during_commit();
        test_back_to_back();
        test_hold_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
